// File: rtl/mib_pkg.sv
// rtl/mib_pkg.sv - shared state encoding and beat constants for the MIB burst master
package mib_pkg;
    localparam int MIB_BEAT_BITS = 16;
    localparam int BACKOFF_CLKS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR1,
        ST_ADDR2,
        ST_TURN,
        ST_DATA,
        ST_BACKOFF,
        ST_DONE
    } mib_state_e;
endpackage

// File: rtl/mib_ack_timer.sv
// rtl/mib_ack_timer.sv - per-beat ACK wait counter; expired_o is high on the LIMIT-th clock of a beat
module mib_ack_timer #(
    parameter int LIMIT = 32
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1) + 1;
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired_q;

    assign cnt_d     = cnt_q + CW'(1);
    assign expired_o = expired_q;

    // cnt_q holds the 1-based index of the current beat clock
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q     <= CW'(1);
            expired_q <= (LIM <= CW'(1));
        end else if (en_i && !expired_q) begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d >= LIM);
        end
    end
endmodule

// File: rtl/mib_burst_master.sv
// rtl/mib_burst_master.sv - single-command MIB burst master with per-beat ACK timeout and retry
module mib_burst_master
    import mib_pkg::*;
#(
    parameter int ADDR_BITS              = 24,
    parameter int DATA_BITS              = 32,
    parameter int P_MIB_ACK_TIMEOUT_CLKS = 32,
    parameter int P_RETRIES              = 0
) (
    input  logic                 i_sysclk,
    input  logic                 i_srst,
    input  logic                 i_cmd_sel,
    input  logic                 i_cmd_rd_wr_n,
    input  logic [ADDR_BITS-1:0] i_cmd_byte_addr,
    input  logic [DATA_BITS-1:0] i_cmd_wdata,
    output logic [DATA_BITS-1:0] o_cmd_rdata,
    output logic                 o_cmd_ack,
    output logic                 o_cmd_mib_timeout,
    output logic                 o_busy,
    output logic [7:0]           o_timeout_cnt,
    input  logic [15:0]          i_mib_ad,
    input  logic                 i_mib_slave_ack,
    output logic                 o_mib_start,
    output logic                 o_mib_rd_wr_n,
    output logic                 o_mib_ad_high_z,
    output logic [15:0]          o_mib_ad
);
    localparam int NBEATS = DATA_BITS / MIB_BEAT_BITS;

    mib_state_e           state_q;
    logic                 rd_q;
    logic [31:0]          addr_q;
    logic [DATA_BITS-1:0] wdata_q, wsh_q, rbuf_q, rdata_q;
    logic [3:0]           beat_q;
    logic [2:0]           retries_q;
    logic [2:0]           bk_q;
    logic                 start_q, mrd_q, hz_q, ack_q, tmo_q, busy_q;
    logic [15:0]          ad_q;
    logic [7:0]           tcnt_q;

    logic [31:0]          cmd_addr;
    logic [DATA_BITS-1:0] rbuf_d;
    logic                 tmr_clr, tmr_en, tmr_expired;

    assign cmd_addr = 32'(i_cmd_byte_addr);
    assign rbuf_d   = (rbuf_q << MIB_BEAT_BITS) | DATA_BITS'(i_mib_ad);
    // the timer restarts on every clock outside DATA and on every accepted beat
    assign tmr_clr  = (state_q != ST_DATA) || i_mib_slave_ack;
    assign tmr_en   = (state_q == ST_DATA);

    mib_ack_timer #(.LIMIT(P_MIB_ACK_TIMEOUT_CLKS)) u_timer (
        .clk_i     (i_sysclk),
        .srst_i    (i_srst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q   <= ST_IDLE;
            rd_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wsh_q     <= '0;
            rbuf_q    <= '0;
            rdata_q   <= '0;
            beat_q    <= '0;
            retries_q <= '0;
            bk_q      <= '0;
            start_q   <= 1'b0;
            mrd_q     <= 1'b1;
            hz_q      <= 1'b1;
            ack_q     <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            ad_q      <= '0;
            tcnt_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_sel) begin
                        rd_q      <= i_cmd_rd_wr_n;
                        addr_q    <= cmd_addr;
                        wdata_q   <= i_cmd_wdata;
                        retries_q <= 3'(P_RETRIES);
                        busy_q    <= 1'b1;
                        mrd_q     <= i_cmd_rd_wr_n;
                        start_q   <= 1'b1;
                        hz_q      <= 1'b0;
                        ad_q      <= cmd_addr[31:16];
                        state_q   <= ST_ADDR1;
                    end
                end
                ST_ADDR1: begin
                    start_q <= 1'b0;
                    ad_q    <= addr_q[15:0];
                    state_q <= ST_ADDR2;
                end
                ST_ADDR2: begin
                    beat_q <= '0;
                    if (rd_q) begin
                        hz_q    <= 1'b1;
                        state_q <= ST_TURN;
                    end else begin
                        ad_q    <= wdata_q[DATA_BITS-1 -: MIB_BEAT_BITS];
                        wsh_q   <= wdata_q << MIB_BEAT_BITS;
                        state_q <= ST_DATA;
                    end
                end
                ST_TURN: state_q <= ST_DATA;
                ST_DATA: begin
                    if (i_mib_slave_ack) begin
                        rbuf_q <= rbuf_d;
                        if (beat_q == 4'(NBEATS - 1)) begin
                            hz_q    <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= ST_DONE;
                            if (rd_q) rdata_q <= rbuf_d;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                            if (!rd_q) begin
                                ad_q  <= wsh_q[DATA_BITS-1 -: MIB_BEAT_BITS];
                                wsh_q <= wsh_q << MIB_BEAT_BITS;
                            end
                        end
                    end else if (tmr_expired) begin
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
                        hz_q <= 1'b1;
                        if (retries_q != 3'd0) begin
                            retries_q <= retries_q - 3'd1;
                            bk_q      <= '0;
                            state_q   <= ST_BACKOFF;
                        end else begin
                            tmo_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (bk_q == 3'(BACKOFF_CLKS - 1)) begin
                        start_q <= 1'b1;
                        hz_q    <= 1'b0;
                        ad_q    <= addr_q[31:16];
                        state_q <= ST_ADDR1;
                    end else begin
                        bk_q <= bk_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_rdata       = rdata_q;
    assign o_cmd_ack         = ack_q;
    assign o_cmd_mib_timeout = tmo_q;
    assign o_busy            = busy_q;
    assign o_timeout_cnt     = tcnt_q;
    assign o_mib_start       = start_q;
    assign o_mib_rd_wr_n     = mrd_q;
    assign o_mib_ad_high_z   = hz_q;
    assign o_mib_ad          = ad_q;
endmodule

// File: tb/tb_mib_burst_master.sv
// tb/tb_mib_burst_master.sv - directed and randomized checks of mib_burst_master against a transaction-level model
module tb_mib_burst_master;
    localparam int TMO     = 8;
    localparam int RETRIES = 2;
    localparam int BKOFF   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst, sel, rdwr, ack, tmo, busy, sack, start, mrd, hz;
    logic [23:0] addr;
    logic [31:0] wdata, rdata;
    logic [7:0]  tcnt;
    logic [15:0] sad, mad;

    logic        b_sel, b_ack, b_tmo, b_busy, b_sack, b_start, b_mrd, b_hz;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_tcnt;
    logic [15:0] b_sad, b_mad;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;
    int          exp_tcnt;

    mib_burst_master #(.ADDR_BITS(24), .DATA_BITS(32), .P_MIB_ACK_TIMEOUT_CLKS(TMO), .P_RETRIES(RETRIES)) dut (
        .i_sysclk(clk), .i_srst(srst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rdwr),
        .i_cmd_byte_addr(addr), .i_cmd_wdata(wdata), .o_cmd_rdata(rdata), .o_cmd_ack(ack),
        .o_cmd_mib_timeout(tmo), .o_busy(busy), .o_timeout_cnt(tcnt), .i_mib_ad(sad),
        .i_mib_slave_ack(sack), .o_mib_start(start), .o_mib_rd_wr_n(mrd),
        .o_mib_ad_high_z(hz), .o_mib_ad(mad)
    );

    mib_burst_master #(.ADDR_BITS(32), .DATA_BITS(64), .P_MIB_ACK_TIMEOUT_CLKS(TMO), .P_RETRIES(0)) dut64 (
        .i_sysclk(clk), .i_srst(srst), .i_cmd_sel(b_sel), .i_cmd_rd_wr_n(1'b0),
        .i_cmd_byte_addr(b_addr), .i_cmd_wdata(b_wdata), .o_cmd_rdata(b_rdata), .o_cmd_ack(b_ack),
        .o_cmd_mib_timeout(b_tmo), .o_busy(b_busy), .o_timeout_cnt(b_tcnt), .i_mib_ad(b_sad),
        .i_mib_slave_ack(b_sack), .o_mib_start(b_start), .o_mib_rd_wr_n(b_mrd),
        .o_mib_ad_high_z(b_hz), .o_mib_ad(b_mad)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command with a cooperative slave; dly[b] idle clocks before the slave ACKs beat b.
    task automatic do_cmd(input logic rd, input logic [23:0] a, input logic [31:0] wd,
                          input int d0, input int d1, input logic [15:0] r0, input logic [15:0] r1,
                          input bit poke);
        logic [15:0] words[2];
        logic [15:0] rw[2];
        int          dl[2];
        words = '{wd[31:16], wd[15:0]};
        rw    = '{r0, r1};
        dl    = '{d0, d1};
        sel = 1'b1; rdwr = rd; addr = a; wdata = wd;
        @(negedge clk);
        sel = 1'b0; addr = 24'($urandom); wdata = $urandom; sack = 1'($urandom);
        chk("addr1_start", start, 1);
        chk("addr1_ad", mad, {8'h00, a[23:16]});
        chk("addr1_hz", hz, 0);
        chk("addr1_busy", busy, 1);
        chk("addr1_rdwr", mrd, rd);
        @(negedge clk);
        sack = 1'($urandom);
        chk("addr2_ad", mad, a[15:0]);
        chk("addr2_start", start, 0);
        if (rd) begin
            @(negedge clk);
            sack = 1'($urandom);
            chk("turn_hz", hz, 1);
        end
        @(negedge clk);
        sack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < dl[b]; k++) begin
                if (poke && b == 0 && k == 0) begin sel = 1'b1; rdwr = ~rd; end
                @(negedge clk);
                sel = 1'b0;
            end
            chk("beat_hz", hz, rd);
            if (!rd) chk("beat_ad", mad, words[b]);
            sack = 1'b1; sad = rw[b];
            @(negedge clk);
            sack = 1'b0; sad = 16'($urandom);
        end
        if (rd) exp_rdata = {r0, r1};
        chk("done_ack", ack, 1);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_hz", hz, 1);
        chk("done_tmo", tmo, 0);
        @(negedge clk);
        chk("post_ack", ack, 0);
        chk("post_busy", busy, 0);
    endtask

    // Silent slave: every attempt times out, retries separated by the backoff gap.
    task automatic do_timeout(input logic rd, input logic [23:0] a);
        int starts, last_start, tmo_at, acks;
        starts = 0; last_start = 0; tmo_at = -1; acks = 0;
        sack = 1'b0;
        sel = 1'b1; rdwr = rd; addr = a; wdata = $urandom;
        @(negedge clk);
        sel = 1'b0;
        for (int t = 1; t < 300; t++) begin
            if (start) begin
                if (starts > 0) chk("retry_gap", t - last_start, 2 + int'(rd) + TMO + BKOFF);
                starts++;
                last_start = t;
            end
            if (ack) acks++;
            if (tmo) begin tmo_at = t; break; end
            @(negedge clk);
        end
        exp_tcnt = (exp_tcnt + RETRIES + 1 > 255) ? 255 : exp_tcnt + RETRIES + 1;
        chk("tmo_seen", tmo_at > 0, 1);
        chk("tmo_attempts", starts, RETRIES + 1);
        chk("tmo_time", tmo_at - last_start, 2 + int'(rd) + TMO);
        chk("tmo_no_ack", acks, 0);
        chk("tmo_cnt", tcnt, exp_tcnt);
        chk("tmo_rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("tmo_pulse_len", tmo, 0);
        chk("tmo_busy", busy, 0);
    endtask

    task automatic do64(input logic [31:0] a, input logic [63:0] wd);
        logic [15:0] exp_w[6];
        exp_w = '{a[31:16], a[15:0], wd[63:48], wd[47:32], wd[31:16], wd[15:0]};
        b_sack = 1'b1; b_sel = 1'b1; b_addr = a; b_wdata = wd;
        @(negedge clk);
        b_sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("b64_word", b_mad, exp_w[i]);
            chk("b64_hz", b_hz, 0);
            @(negedge clk);
        end
        chk("b64_ack", b_ack, 1);
        b_sack = 1'b0;
        @(negedge clk);
        chk("b64_busy", b_busy, 0);
    endtask

    initial begin
        int t64;
        srst = 1'b1; sel = 1'b0; rdwr = 1'b0; addr = '0; wdata = '0; sack = 1'b0; sad = '0;
        b_sel = 1'b0; b_addr = '0; b_wdata = '0; b_sack = 1'b0; b_sad = '0;
        exp_rdata = '0; exp_tcnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_rdwr", mrd, 1);
        chk("rst_hz", hz, 1);
        chk("rst_ad", mad, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_tcnt", tcnt, 0);
        srst = 1'b0;
        @(negedge clk);

        do_cmd(1'b0, 24'h000004, 32'h01010202, 2, 2, 16'h0, 16'h0, 1'b0);
        do_cmd(1'b1, 24'h000008, 32'h0, 1, 3, 16'hDEAD, 16'hBEEF, 1'b0);
        do_cmd(1'b0, 24'($urandom), $urandom, TMO - 1, TMO - 1, 16'h0, 16'h0, 1'b1);
        do_cmd(1'b1, 24'($urandom), $urandom, TMO - 1, 0, 16'($urandom), 16'($urandom), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_start", start, 0);
        end
        for (int i = 0; i < 12; i++)
            do_cmd(1'($urandom), 24'($urandom), $urandom, $urandom_range(0, TMO - 1),
                   $urandom_range(0, TMO - 1), 16'($urandom), 16'($urandom), 1'b0);

        do_timeout(1'b0, 24'($urandom));
        do_timeout(1'b1, 24'($urandom));
        do_cmd(1'b1, 24'($urandom), $urandom, 0, 2, 16'($urandom), 16'($urandom), 1'b0);

        do64(32'h0000_0010, 64'h1122334455667788);
        for (int i = 0; i < 3; i++) do64($urandom, {$urandom, $urandom});

        b_sack = 1'b0; b_sel = 1'b1; b_addr = $urandom;
        @(negedge clk);
        b_sel = 1'b0;
        t64 = -1;
        for (int t = 1; t < 100; t++) begin
            if (b_ack) chk("b64_tmo_no_ack", b_ack, 0);
            if (b_tmo) begin t64 = t; break; end
            @(negedge clk);
        end
        chk("b64_tmo_time", t64, 3 + TMO);
        chk("b64_tmo_cnt", b_tcnt, 1);
        @(negedge clk);

        // abort a read in its second beat
        sel = 1'b1; rdwr = 1'b1; addr = 24'($urandom);
        @(negedge clk);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        sack = 1'b1; sad = 16'hAAAA;
        @(negedge clk);
        sack = 1'b0;
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        exp_rdata = '0; exp_tcnt = 0;
        chk("srst_start", start, 0);
        chk("srst_rdwr", mrd, 1);
        chk("srst_hz", hz, 1);
        chk("srst_ad", mad, 0);
        chk("srst_ack", ack, 0);
        chk("srst_tmo", tmo, 0);
        chk("srst_busy", busy, 0);
        chk("srst_rdata", rdata, 0);
        chk("srst_tcnt", tcnt, 0);
        for (int i = 0; i < TMO + 4; i++) begin
            @(negedge clk);
            chk("srst_quiet", {ack, tmo, busy}, 3'b000);
        end
        do_cmd(1'b0, 24'($urandom), $urandom, 1, 0, 16'h0, 16'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
